dmem_stage: RTL



---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_mem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Wait counter width; covers WAIT_CYCLES up to 15.
  localparam int WAIT_W = 4;

  // Bytes per RAM word; the low log2(WORD_BYTES) address bits select a byte.
  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with a registered, read-first read port.
// Latency: write commits at the edge; rdata shows mem[addr] one edge after addr.
// Backpressure: none; one access per cycle.
//
// Ports:
//   clk    rising-edge clock
//   we     write enable for this edge
//   addr   word index (read every cycle, written when we)
//   wdata  write data
//   rdata  registered read data (old contents on a same-edge write)
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_stage.sv
// MIPS MEM stage: word loads/stores against an internal RAM with fixed latency.
// Latency: aligned request in cycle T stalls T..T+WAIT_CYCLES-1; data valid in T+WAIT_CYCLES.
// Backpressure: mem_stall freezes the upstream pipeline while an access is in flight.
//
// Ports:
//   clk, rst_n   pipeline clock, synchronous active-low reset
//   MemRead      load request from EX/MEM
//   MemWrite     store request from EX/MEM (wins when both are high)
//   Address      byte address; word index is Address[log2(DEPTH)+1:2]
//   Write_data   store data
//   Read_data    load data to MEM/WB (holds between loads)
//   mem_stall    hazard-unit stall, combinational from state and request
//   mem_err      one-cycle pulse after a misaligned or conflicting request
module dmem_stage
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              req;
  logic              aligned;
  logic              access;
  logic              err_d;
  logic              err_q;
  logic              is_load_q;
  logic              load_out;
  logic              ram_we;
  logic [AW-1:0]     word_idx;
  logic [31:0]       ram_rdata;
  logic [31:0]       hold_q;
  logic              unused_addr_hi;

  assign req      = MemRead | MemWrite;
  assign aligned  = (Address[OFF_W-1:0] == '0);
  assign word_idx = Address[AW+OFF_W-1:OFF_W];

  // Upper address bits are ignored so addresses wrap modulo DEPTH words.
  assign unused_addr_hi = ^Address[31:AW+OFF_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    access    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (aligned) begin
            mem_stall = 1'b1;
            cnt_d     = WAIT_W'(1);
            // A store with a simultaneous read request is flagged but still performed.
            err_d     = MemRead & MemWrite;
            if (WAIT_CYCLES == 1) begin
              access  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = ACCESS;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        if (cnt_q == LAST_CNT) begin
          access  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // EX/MEM advances at the end of this cycle, so the held request is dropped.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gated by rst_n so a reset landing on the access edge discards the store.
  assign ram_we = access & MemWrite & rst_n;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (word_idx),
    .wdata (Write_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      is_load_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (access) begin
        is_load_q <= MemRead & ~MemWrite;
      end
      if (load_out) begin
        hold_q <= ram_rdata;
      end
    end
  end

  // The RAM read register captures the word at the access edge, so it already
  // holds the load result in DONE; hold_q keeps that value afterwards. Both
  // sources are flops, so Read_data stays a registered value.
  assign load_out  = (state_q == DONE) && is_load_q;
  assign Read_data = load_out ? ram_rdata : hold_q;
  assign mem_err   = err_q;

endmodule
